// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: one word-aligned data-memory access at a time over req/gnt/rvalid
// Optional alignment rejection of misaligned half/word accesses: LSU_ALIGN_CHECK_EN
module lsu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [1:0]            type_i,
    input  logic                  sign_ext_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic [DATA_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic [DATA_WIDTH-1:0] data_rdata_i
);

    localparam logic [1:0] T_BYTE = 2'b00;
    localparam logic [1:0] T_HALF = 2'b01;
    localparam logic [1:0] T_WORD = 2'b10;
    localparam logic [1:0] T_INV  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10
    } state_t;

    state_t                state;
    logic                  we_q;
    logic                  sign_q;
    logic [1:0]            type_q;
    logic [1:0]            off_q;
    logic [3:0]            be_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  reject;
    logic                  accept;
    logic                  done;
    logic [1:0]            off_in;
    logic [3:0]            be_in;
    logic [DATA_WIDTH-1:0] wdata_in;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] load_ext;

    // Lane offset is forced to natural alignment so misaligned accesses
    // (when not rejected) select the aligned lanes.
    always_comb begin
`ifdef LSU_ALIGN_CHECK_EN
        reject = (type_i == T_INV) ||
                 ((type_i == T_HALF) && addr_i[0]) ||
                 ((type_i == T_WORD) && (addr_i[1:0] != 2'b00));
`else
        reject = (type_i == T_INV);
`endif
        case (type_i)
            T_BYTE:  off_in = addr_i[1:0];
            T_HALF:  off_in = {addr_i[1], 1'b0};
            default: off_in = 2'b00;
        endcase
        case (type_i)
            T_BYTE: begin
                be_in    = 4'b0001 << off_in;
                wdata_in = {4{wdata_i[7:0]}};
            end
            T_HALF: begin
                be_in    = 4'b0011 << off_in;
                wdata_in = {2{wdata_i[15:0]}};
            end
            default: begin
                be_in    = 4'b1111;
                wdata_in = wdata_i;
            end
        endcase
    end

    assign accept = (state == S_IDLE) && req_i && !reject;
    assign done   = (state == S_WAIT) && data_rvalid_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            type_q  <= 2'b00;
            off_q   <= 2'b00;
            be_q    <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state   <= S_REQ;
                        we_q    <= we_i;
                        sign_q  <= sign_ext_i;
                        type_q  <= type_i;
                        off_q   <= off_in;
                        be_q    <= be_in;
                        addr_q  <= {addr_i[DATA_WIDTH-1:2], 2'b00};
                        wdata_q <= wdata_in;
                    end
                end
                S_REQ: begin
                    if (data_gnt_i) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (data_rvalid_i) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        shifted = data_rdata_i >> {off_q, 3'b000};
        case (type_q)
            T_BYTE:  load_ext = {{(DATA_WIDTH-8){sign_q & shifted[7]}}, shifted[7:0]};
            T_HALF:  load_ext = {{(DATA_WIDTH-16){sign_q & shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    assign busy_o       = accept || (state == S_REQ) || ((state == S_WAIT) && !data_rvalid_i);
    assign done_o       = done;
    assign err_o        = (state == S_IDLE) && req_i && reject;
    assign rdata_o      = (done && !we_q) ? load_ext : '0;
    assign data_req_o   = (state == S_REQ);
    assign data_addr_o  = addr_q;
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - randomized and directed self-checking bench for lsu against a behavioural model
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [1:0]  type_i;
    logic        sign_ext_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu #(.DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req_i),
        .we_i          (we_i),
        .type_i        (type_i),
        .sign_ext_i    (sign_ext_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .rdata_o       (rdata_o),
        .err_o         (err_o),
        .data_req_o    (data_req_o),
        .data_gnt_i    (data_gnt_i),
        .data_addr_o   (data_addr_o),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_wdata_o  (data_wdata_o),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit align_check_on();
`ifdef LSU_ALIGN_CHECK_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_reject(input logic [1:0] t, input logic [31:0] a);
        if (t == 2'd3) return 1'b1;
        if (!align_check_on()) return 1'b0;
        if (t == 2'd1 && (a % 2) != 0) return 1'b1;
        if (t == 2'd2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_off(input logic [1:0] t, input logic [31:0] a);
        if (t == 2'd0) return int'(a % 4);
        if (t == 2'd1) return int'((a / 2) % 2) * 2;
        return 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] t, input logic [31:0] a);
        int o = m_off(t, a);
        if (t == 2'd0) return 4'(1 << o);
        if (t == 2'd1) return 4'(3 << o);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] t, input logic [31:0] d);
        if (t == 2'd0) return (d % 256) * 32'h0101_0101;
        if (t == 2'd1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] t, input logic s, input logic [31:0] a,
                                           input logic [31:0] mem);
        logic [31:0] v = mem / (32'd1 << (8 * m_off(t, a)));
        if (t == 2'd0) begin
            v = v % 256;
            if (s && v >= 128) v = v - 256;
        end else if (t == 2'd1) begin
            v = v % 65536;
            if (s && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    task automatic do_access(input logic we, input logic [1:0] t, input logic s, input logic [31:0] a,
                             input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                             input logic stray, input logic [31:0] mem);
        bit          rej;
        logic [31:0] exp_rd;
        rej    = m_reject(t, a);
        exp_rd = we ? 32'h0 : m_load(t, s, a, mem);
        @(posedge clk); #1;
        req_i = 1'b1; we_i = we; type_i = t; sign_ext_i = s; addr_i = a; wdata_i = wd;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        @(negedge clk);
        check_eq("acc_err", 32'(err_o), 32'(rej));
        check_eq("acc_busy", 32'(busy_o), 32'(!rej));
        check_eq("acc_req", 32'(data_req_o), 0);
        check_eq("acc_done", 32'(done_o), 0);
        if (rej) begin
            @(posedge clk); #1;
            req_i = 1'b0;
            @(negedge clk);
            check_eq("rej_req", 32'(data_req_o), 0);
            check_eq("rej_busy", 32'(busy_o), 0);
            return;
        end
        for (int k = 0; k <= gnt_dly; k++) begin
            @(posedge clk); #1;
            data_gnt_i    = (k == gnt_dly);
            data_rvalid_i = stray && (k == 0);
            data_rdata_i  = $urandom;
            @(negedge clk);
            check_eq("req_req", 32'(data_req_o), 1);
            check_eq("req_addr", data_addr_o, a & 32'hFFFF_FFFC);
            check_eq("req_be", 32'(data_be_o), 32'(m_be(t, a)));
            check_eq("req_wdata", data_wdata_o, m_wdata(t, wd));
            check_eq("req_we", 32'(data_we_o), 32'(we));
            check_eq("req_busy", 32'(busy_o), 1);
            check_eq("req_done", 32'(done_o), 0);
        end
        for (int k = 0; k <= rv_dly; k++) begin
            @(posedge clk); #1;
            data_gnt_i    = 1'b0;
            data_rvalid_i = (k == rv_dly);
            data_rdata_i  = (k == rv_dly) ? mem : $urandom;
            @(negedge clk);
            check_eq("wait_req", 32'(data_req_o), 0);
            check_eq("wait_done", 32'(done_o), 32'(k == rv_dly));
            check_eq("wait_busy", 32'(busy_o), 32'(k != rv_dly));
            check_eq("wait_rdata", rdata_o, (k == rv_dly) ? exp_rd : 32'h0);
        end
    endtask

    initial begin
        rst = 1'b1; req_i = 1'b0; we_i = 1'b0; type_i = 2'b00; sign_ext_i = 1'b0;
        addr_i = '0; wdata_i = '0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req", 32'(data_req_o), 0);
        check_eq("rst_addr", data_addr_o, 0);
        check_eq("rst_be", 32'(data_be_o), 0);
        check_eq("rst_wdata", data_wdata_o, 0);
        check_eq("rst_we", 32'(data_we_o), 0);
        check_eq("rst_busy", 32'(busy_o), 0);
        check_eq("rst_done", 32'(done_o), 0);
        check_eq("rst_err", 32'(err_o), 0);
        check_eq("rst_rdata", rdata_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 0, 1'b0, 32'hDEAD_BEEF);
        do_access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 0, 1'b0, 32'h8011_2233);
        do_access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1, 2, 1'b0, 32'h8011_2233);
        do_access(1'b1, 2'd1, 1'b0, 32'h202, 32'h1234_ABCD, 3, 1, 1'b0, 32'h5555_5555);
        do_access(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0, 0, 1'b0, 32'h0BAD_F00D);
        do_access(1'b0, 2'd1, 1'b1, 32'h103, 32'h0, 0, 0, 1'b0, 32'hF00F_1234);
        do_access(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 0, 0, 1'b0, 32'h0);
        do_access(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 2, 0, 1'b1, 32'h8001_7FFF);

        // Reset while waiting for rvalid; a stray response afterwards must not complete anything.
        @(posedge clk); #1;
        req_i = 1'b1; we_i = 1'b0; type_i = 2'd2; addr_i = 32'h40; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        @(posedge clk); #1;
        data_gnt_i = 1'b1;
        @(posedge clk); #1;
        data_gnt_i = 1'b0; rst = 1'b1; req_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rstw_req", 32'(data_req_o), 0);
        check_eq("rstw_busy", 32'(busy_o), 0);
        @(posedge clk); #1;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_5678;
        @(negedge clk);
        check_eq("stray_done", 32'(done_o), 0);
        check_eq("stray_rdata", rdata_o, 0);
        check_eq("stray_busy", 32'(busy_o), 0);
        do_access(1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 0, 0, 1'b0, 32'hCAFE_0001);

        // Reset while requesting: the request must drop right after the reset edge.
        @(posedge clk); #1;
        req_i = 1'b1; type_i = 2'd2; addr_i = 32'h80; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; req_i = 1'b0;
        @(negedge clk);
        check_eq("rstr_req_before", 32'(data_req_o), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rstr_req_after", 32'(data_req_o), 0);

        for (int i = 0; i < 300; i++) begin
            do_access(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), $urandom);
        end

        @(posedge clk); #1;
        req_i = 1'b0; data_rvalid_i = 1'b0; data_gnt_i = 1'b0;
        @(negedge clk);
        check_eq("end_busy", 32'(busy_o), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
